hazard_scoreboard: RTL and testbench

//  Pipeline hazard and writeback controller for the 5-stage core with the multi-cycle mul/div unit.

---
 rtl/hazard_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard / writeback controller: mul/div scoreboard, D-stage stall,
// X-stage forwarding, regfile write-port arbitration and mul/div timeout.
module hazard_scoreboard #(
  parameter int unsigned NREGS      = 32,
  parameter int unsigned RW         = 5,
  parameter int unsigned DW         = 32,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [RW-1:0] fd_rs_a,
  input  logic [RW-1:0] fd_rs_b,
  input  logic          fd_use_a,
  input  logic          fd_use_b,
  input  logic [RW-1:0] fd_rd,
  input  logic          fd_we,
  input  logic          fd_is_md,
  input  logic [RW-1:0] dx_rs_a,
  input  logic [RW-1:0] dx_rs_b,
  input  logic [RW-1:0] dx_rd,
  input  logic          dx_we,
  input  logic          dx_is_load,
  input  logic [RW-1:0] xm_rd,
  input  logic          xm_we,
  input  logic [RW-1:0] mw_rd,
  input  logic          mw_we,
  input  logic          md_start,
  input  logic          md_rdy,
  input  logic [DW-1:0] md_result,
  input  logic          branch_taken,
  output logic          stall_pc,
  output logic          stall_fd,
  output logic          bubble_dx,
  output logic          flush_fd,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          reg_we,
  output logic [RW-1:0] reg_wr,
  output logic          wb_md_sel,
  output logic [DW-1:0] wb_md_data,
  output logic          md_busy,
  output logic          md_err
);

  localparam int unsigned TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  logic [NREGS-1:0] pending;
  logic [RW-1:0]    md_rd_q;
  logic             hold_v;
  logic [RW-1:0]    hold_rd;
  logic [DW-1:0]    hold_data;
  logic [TW-1:0]    tmo_cnt;

  logic             mw_w, md_fresh, md_w, md_wr_now;
  logic             md_accept, md_illegal, md_tmo;
  logic [RW-1:0]    md_dest;
  logic [NREGS-1:0] clr_mask, set_mask, tmo_mask, pend_d;
  logic             hazard;

  // Mul/div issue/complete qualification and regfile write-port arbitration
  always_comb begin
    mw_w       = mw_we & (mw_rd != '0);
    md_fresh   = md_rdy & md_busy;
    md_w       = md_fresh | hold_v;
    md_dest    = hold_v ? hold_rd : md_rd_q;
    md_wr_now  = md_w & ~mw_w;
    md_illegal = md_start & md_busy & ~md_rdy;
    md_accept  = md_start & (dx_rd != '0) & ~(md_busy & ~md_rdy);
    md_tmo     = md_busy & ~md_rdy & (tmo_cnt == TW'(MD_TIMEOUT - 1));
    clr_mask   = md_wr_now ? (NREGS'(1) << md_dest) : '0;
    set_mask   = md_accept ? (NREGS'(1) << dx_rd) : '0;
    tmo_mask   = md_tmo ? (NREGS'(1) << md_rd_q) : '0;
    // D stage sees a register freed by this cycle's write and one claimed by this cycle's issue
    pend_d     = ((pending & ~clr_mask) | set_mask) & ~NREGS'(1);
    reg_we     = 1'b0;
    reg_wr     = '0;
    wb_md_sel  = 1'b0;
    wb_md_data = '0;
    if (mw_w) begin
      reg_we = 1'b1;
      reg_wr = mw_rd;
    end else if (md_w) begin
      reg_we     = 1'b1;
      reg_wr     = md_dest;
      wb_md_sel  = 1'b1;
      wb_md_data = hold_v ? hold_data : md_result;
    end
  end

  // D-stage hazard detection; a taken branch squashes instead of stalling
  always_comb begin
    hazard = (dx_is_load & dx_we & (dx_rd != '0) &
              ((fd_use_a & (fd_rs_a == dx_rd)) | (fd_use_b & (fd_rs_b == dx_rd))))
           | (fd_use_a & pend_d[fd_rs_a])
           | (fd_use_b & pend_d[fd_rs_b])
           | (fd_we & pend_d[fd_rd])
           | (fd_is_md & md_busy & ~md_rdy);
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    bubble_dx = 1'b0;
    flush_fd  = 1'b0;
    if (branch_taken) begin
      flush_fd  = 1'b1;
      bubble_dx = 1'b1;
    end else if (hazard) begin
      stall_pc  = 1'b1;
      stall_fd  = 1'b1;
      bubble_dx = 1'b1;
    end
  end

  // X-stage operand select: XM > MW > mul/div writeback > regfile, r0 never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (dx_rs_a != '0) begin
      if (xm_we && xm_rd == dx_rs_a)           fwd_a = 2'b01;
      else if (mw_w && mw_rd == dx_rs_a)       fwd_a = 2'b10;
      else if (md_wr_now && md_dest == dx_rs_a) fwd_a = 2'b11;
    end
    if (dx_rs_b != '0) begin
      if (xm_we && xm_rd == dx_rs_b)           fwd_b = 2'b01;
      else if (mw_w && mw_rd == dx_rs_b)       fwd_b = 2'b10;
      else if (md_wr_now && md_dest == dx_rs_b) fwd_b = 2'b11;
    end
  end

  // Scoreboard: clear on result write or timeout, set on accepted issue
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= ((pending & ~clr_mask & ~tmo_mask) | set_mask) & ~NREGS'(1);
  end

  // Mul/div tracking: busy flag, destination, timeout counter, sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_busy <= 1'b0;
      md_rd_q <= '0;
      tmo_cnt <= '0;
      md_err  <= 1'b0;
    end else begin
      if (md_illegal || md_tmo) md_err <= 1'b1;
      if (md_accept) begin
        md_busy <= 1'b1;
        md_rd_q <= dx_rd;
        tmo_cnt <= '0;
      end else if (md_fresh || md_tmo) begin
        md_busy <= 1'b0;
      end else if (md_busy) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // Hold buffer for a mul/div result that lost the write port to MW
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_v    <= 1'b0;
      hold_rd   <= '0;
      hold_data <= '0;
    end else if (mw_w && md_fresh && !hold_v) begin
      hold_v    <= 1'b1;
      hold_rd   <= md_rd_q;
      hold_data <= md_result;
    end else if (md_wr_now && hold_v) begin
      hold_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_hazard_scoreboard;

  logic        clock, reset;
  logic [4:0]  fd_rs_a, fd_rs_b, fd_rd, dx_rs_a, dx_rs_b, dx_rd, xm_rd, mw_rd;
  logic        fd_use_a, fd_use_b, fd_we, fd_is_md, dx_we, dx_is_load, xm_we, mw_we;
  logic        md_start, md_rdy, branch_taken;
  logic [31:0] md_result;
  logic        stall_pc, stall_fd, bubble_dx, flush_fd, reg_we, wb_md_sel, md_busy, md_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  reg_wr;
  logic [31:0] wb_md_data;

  int passed = 0;
  int total  = 0;

  hazard_scoreboard dut (
    .clock(clock), .reset(reset),
    .fd_rs_a(fd_rs_a), .fd_rs_b(fd_rs_b), .fd_use_a(fd_use_a), .fd_use_b(fd_use_b),
    .fd_rd(fd_rd), .fd_we(fd_we), .fd_is_md(fd_is_md),
    .dx_rs_a(dx_rs_a), .dx_rs_b(dx_rs_b), .dx_rd(dx_rd), .dx_we(dx_we), .dx_is_load(dx_is_load),
    .xm_rd(xm_rd), .xm_we(xm_we), .mw_rd(mw_rd), .mw_we(mw_we),
    .md_start(md_start), .md_rdy(md_rdy), .md_result(md_result), .branch_taken(branch_taken),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .bubble_dx(bubble_dx), .flush_fd(flush_fd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .reg_we(reg_we), .reg_wr(reg_wr),
    .wb_md_sel(wb_md_sel), .wb_md_data(wb_md_data), .md_busy(md_busy), .md_err(md_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [48:0] out_vec;
  assign out_vec = {stall_pc, stall_fd, bubble_dx, flush_fd, fwd_a, fwd_b,
                    reg_we, reg_wr, wb_md_sel, wb_md_data, md_busy, md_err};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic clear_inputs();
    {fd_rs_a, fd_rs_b, fd_rd, dx_rs_a, dx_rs_b, dx_rd, xm_rd, mw_rd} = '0;
    {fd_use_a, fd_use_b, fd_we, fd_is_md, dx_we, dx_is_load, xm_we, mw_we} = '0;
    {md_start, md_rdy, branch_taken} = '0;
    md_result = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // ---------------- combinational vector table ----------------
  typedef struct {
    string      nm;
    logic [4:0] frsa, frsb, frd, drsa, drsb, drd, xrd, mrd;
    logic       ua, ub, fwe, ld, dwe, xwe, mwe, br;
    logic [3:0] e_ctl;   // {stall_pc, stall_fd, bubble_dx, flush_fd}
    logic [1:0] e_fa, e_fb;
    logic       e_we;
    logic [4:0] e_wr;
  } vec_t;

  function automatic vec_t mk(string nm,
      logic [4:0] frsa, logic ua, logic [4:0] frsb, logic ub, logic [4:0] frd, logic fwe,
      logic ld, logic [4:0] drd, logic dwe, logic [4:0] drsa, logic [4:0] drsb,
      logic [4:0] xrd, logic xwe, logic [4:0] mrd, logic mwe, logic br,
      logic [3:0] e_ctl, logic [1:0] e_fa, logic [1:0] e_fb, logic e_we, logic [4:0] e_wr);
    vec_t v;
    v.nm = nm; v.frsa = frsa; v.ua = ua; v.frsb = frsb; v.ub = ub; v.frd = frd; v.fwe = fwe;
    v.ld = ld; v.drd = drd; v.dwe = dwe; v.drsa = drsa; v.drsb = drsb;
    v.xrd = xrd; v.xwe = xwe; v.mrd = mrd; v.mwe = mwe; v.br = br;
    v.e_ctl = e_ctl; v.e_fa = e_fa; v.e_fb = e_fb; v.e_we = e_we; v.e_wr = e_wr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  bit          m_pend [32];
  bit          m_busy, m_hv, m_err;
  int          m_rdq, m_hrd, m_cnt;
  logic [31:0] m_hdata;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_busy = 0; m_hv = 0; m_err = 0; m_rdq = 0; m_hrd = 0; m_cnt = 0; m_hdata = '0;
  endtask

  function automatic bit md_writes_now();
    bit mw_ok = mw_we && mw_rd != 0;
    return (m_hv || (md_rdy && m_busy)) && !mw_ok;
  endfunction

  function automatic int md_target();
    return m_hv ? m_hrd : m_rdq;
  endfunction

  function automatic bit issue_ok();
    return md_start && dx_rd != 0 && !(m_busy && !md_rdy);
  endfunction

  // register r blocks the D stage if an unretired mul/div op targets it
  function automatic bit blocked(int r);
    if (r == 0) return 0;
    if (issue_ok() && r == int'(dx_rd)) return 1;
    if (md_writes_now() && r == md_target()) return 0;
    return m_pend[r];
  endfunction

  function automatic logic [1:0] pick(int rs);
    if (rs == 0) return 2'b00;
    if (xm_we && int'(xm_rd) == rs) return 2'b01;
    if (mw_we && mw_rd != 0 && int'(mw_rd) == rs) return 2'b10;
    if (md_writes_now() && md_target() == rs) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [48:0] model_out();
    bit st, we, sel;
    logic [3:0] ctl;
    logic [4:0] wr;
    logic [31:0] data;
    st = (dx_is_load && dx_we && dx_rd != 0 &&
          ((fd_use_a && fd_rs_a == dx_rd) || (fd_use_b && fd_rs_b == dx_rd)))
      || (fd_use_a && blocked(int'(fd_rs_a))) || (fd_use_b && blocked(int'(fd_rs_b)))
      || (fd_we && blocked(int'(fd_rd))) || (fd_is_md && m_busy && !md_rdy);
    if (branch_taken) ctl = 4'b0011;
    else if (st)      ctl = 4'b1110;
    else              ctl = 4'b0000;
    we = 0; sel = 0; wr = 0; data = 0;
    if (mw_we && mw_rd != 0) begin
      we = 1; wr = mw_rd;
    end else if (m_hv || (md_rdy && m_busy)) begin
      we = 1; sel = 1; wr = 5'(md_target()); data = m_hv ? m_hdata : md_result;
    end
    return {ctl, pick(int'(dx_rs_a)), pick(int'(dx_rs_b)), we, wr, sel, data, m_busy, m_err};
  endfunction

  task automatic model_step();
    bit fresh = md_rdy && m_busy;
    bit mw_ok = mw_we && mw_rd != 0;
    bit wnow  = md_writes_now();
    bit acc   = issue_ok();
    bit tmo   = m_busy && !md_rdy && m_cnt == 63;
    int tgt   = md_target();
    bit hv0   = m_hv;
    if (md_start && m_busy && !md_rdy) m_err = 1;
    if (wnow) begin
      m_pend[tgt] = 0;
      if (hv0) m_hv = 0;
    end
    if (mw_ok && fresh && !hv0) begin
      m_hv = 1; m_hrd = m_rdq; m_hdata = md_result;
    end
    if (tmo) begin
      m_err = 1; m_pend[m_rdq] = 0;
    end
    if (acc) begin
      m_pend[dx_rd] = 1; m_rdq = int'(dx_rd); m_busy = 1; m_cnt = 0;
    end else if (fresh || tmo) begin
      m_busy = 0;
    end else if (m_busy) begin
      m_cnt++;
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];
  int   stall_cnt;

  initial begin
    vecs.push_back(mk("idle",        0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0, 4'b0000, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("alu_fwd_xm",  3,0,3,0,4,1, 0,0,0, 3,3, 3,1, 0,0, 0, 4'b0000, 2'b01,2'b01, 0,0));
    vecs.push_back(mk("load_use_a",  5,1,0,0,6,1, 1,5,1, 0,0, 0,0, 0,0, 0, 4'b1110, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("load_use_b",  1,1,5,1,6,1, 1,5,1, 0,0, 0,0, 0,0, 0, 4'b1110, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("lu_unused",   5,0,0,0,6,1, 1,5,1, 0,0, 0,0, 0,0, 0, 4'b0000, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("load_r0",     0,1,0,1,6,1, 1,0,1, 0,0, 0,0, 0,0, 0, 4'b0000, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("not_load",    5,1,0,0,6,1, 0,5,1, 0,0, 0,0, 0,0, 0, 4'b0000, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("br_over_lu",  5,1,0,0,6,1, 1,5,1, 0,0, 0,0, 0,0, 1, 4'b0011, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("br_alone",    0,0,0,0,0,0, 0,0,0, 0,0, 0,0, 0,0, 1, 4'b0011, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("mw_fwd",      0,0,0,0,0,0, 0,0,0, 5,0, 0,0, 5,1, 0, 4'b0000, 2'b10,2'b00, 1,5));
    vecs.push_back(mk("xm_over_mw",  0,0,0,0,0,0, 0,0,0, 6,6, 6,1, 6,1, 0, 4'b0000, 2'b01,2'b01, 1,6));
    vecs.push_back(mk("r0_no_fwd",   0,0,0,0,0,0, 0,0,0, 0,0, 0,1, 0,1, 0, 4'b0000, 2'b00,2'b00, 0,0));
    vecs.push_back(mk("mw_b_only",   0,0,0,0,0,0, 0,0,0, 2,4, 2,0, 4,1, 0, 4'b0000, 2'b00,2'b10, 1,4));

    clear_inputs();
    reset = 1'b1;
    #2;
    chk("reset_outputs", 64'(out_vec), 64'd0);
    do_reset();

    foreach (vecs[i]) begin
      clear_inputs();
      fd_rs_a = vecs[i].frsa; fd_use_a = vecs[i].ua; fd_rs_b = vecs[i].frsb; fd_use_b = vecs[i].ub;
      fd_rd = vecs[i].frd; fd_we = vecs[i].fwe; dx_is_load = vecs[i].ld; dx_rd = vecs[i].drd;
      dx_we = vecs[i].dwe; dx_rs_a = vecs[i].drsa; dx_rs_b = vecs[i].drsb;
      xm_rd = vecs[i].xrd; xm_we = vecs[i].xwe; mw_rd = vecs[i].mrd; mw_we = vecs[i].mwe;
      branch_taken = vecs[i].br;
      @(negedge clock);
      chk(vecs[i].nm, 64'({stall_pc, stall_fd, bubble_dx, flush_fd, fwd_a, fwd_b, reg_we, reg_wr}),
          64'({vecs[i].e_ctl, vecs[i].e_fa, vecs[i].e_fb, vecs[i].e_we, vecs[i].e_wr}));
    end

    // mul r7 followed by add r8,r7,r1 held in D until the result is written
    clear_inputs();
    stall_cnt = 0;
    for (int c = 0; c <= 32; c++) begin
      clear_inputs();
      fd_rs_a = 7; fd_use_a = 1; fd_rs_b = 1; fd_use_b = 1; fd_rd = 8; fd_we = 1;
      if (c == 0) begin md_start = 1; dx_rd = 7; dx_we = 1; end
      if (c == 32) begin md_rdy = 1; md_result = 32'hDEAD_BEEF; dx_rs_a = 7; end
      @(negedge clock);
      if (c < 32) stall_cnt += int'(stall_pc);
      if (c == 1) chk("mul_busy", 64'(md_busy), 64'd1);
      if (c == 32) begin
        chk("mul_stall_cycles", 64'(stall_cnt), 64'd32);
        chk("mul_release_ctl", 64'({stall_pc, stall_fd, bubble_dx}), 64'd0);
        chk("mul_release_wb", 64'({reg_we, wb_md_sel, reg_wr}), 64'({2'b11, 5'd7}));
        chk("mul_release_data", 64'(wb_md_data), 64'h0000_0000_DEAD_BEEF);
        chk("mul_release_fwd", 64'(fwd_a), 64'd3);
      end
      tick();
    end
    clear_inputs();
    fd_rs_a = 7; fd_use_a = 1;
    @(negedge clock);
    chk("mul_after", 64'({md_busy, stall_pc, reg_we}), 64'd0);
    tick();

    // mul/div result colliding with an MW write is held and retried
    clear_inputs(); md_start = 1; dx_rd = 10; tick();
    clear_inputs(); tick();
    clear_inputs(); md_rdy = 1; md_result = 32'h1234_5678; mw_we = 1; mw_rd = 9;
    @(negedge clock);
    chk("coll_mw_wins", 64'({reg_we, wb_md_sel, reg_wr}), 64'({2'b10, 5'd9}));
    tick();
    clear_inputs(); mw_we = 1; mw_rd = 9; fd_rs_a = 10; fd_use_a = 1;
    @(negedge clock);
    chk("coll_hold_retry", 64'({stall_pc, reg_we, wb_md_sel, reg_wr}), 64'({3'b110, 5'd9}));
    tick();
    clear_inputs(); fd_rs_a = 10; fd_use_a = 1; dx_rs_b = 10;
    @(negedge clock);
    chk("coll_drain_wb", 64'({reg_we, wb_md_sel, reg_wr}), 64'({2'b11, 5'd10}));
    chk("coll_drain_data", 64'(wb_md_data), 64'h1234_5678);
    chk("coll_drain_fwd_stall", 64'({fwd_b, stall_pc}), 64'({2'b11, 1'b0}));
    tick();
    @(negedge clock);
    chk("coll_after", 64'({reg_we, stall_pc}), 64'd0);
    tick();

    // mul/div issue while busy is ignored and flagged
    clear_inputs(); md_start = 1; dx_rd = 12; tick();
    clear_inputs(); md_start = 1; dx_rd = 13; tick();
    clear_inputs(); fd_rs_a = 13; fd_use_a = 1;
    @(negedge clock);
    chk("illegal_issue", 64'({md_err, md_busy, stall_pc}), 64'({3'b110}));
    do_reset();

    // md_rdy with nothing in flight writes nothing
    md_rdy = 1; md_result = 32'hCAFE_F00D;
    @(negedge clock);
    chk("rdy_idle", 64'({reg_we, wb_md_sel, md_busy}), 64'd0);
    tick();

    // timeout after 64 busy cycles, cleared only by reset
    clear_inputs(); md_start = 1; dx_rd = 11; tick();
    clear_inputs(); fd_rs_a = 11; fd_use_a = 1;
    for (int i = 0; i < 63; i++) tick();
    @(negedge clock);
    chk("tmo_last_busy", 64'({md_busy, md_err, stall_pc}), 64'({3'b101}));
    tick();
    @(negedge clock);
    chk("tmo_fired", 64'({md_busy, md_err, stall_pc}), 64'({3'b010}));
    tick();
    do_reset();
    @(negedge clock);
    chk("tmo_reset_clears", 64'(out_vec), 64'd0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      fd_rs_a = 5'($urandom_range(0, 3)); fd_rs_b = 5'($urandom_range(0, 3));
      fd_rd = 5'($urandom_range(0, 3));   dx_rs_a = 5'($urandom_range(0, 3));
      dx_rs_b = 5'($urandom_range(0, 3)); dx_rd = 5'($urandom_range(0, 3));
      xm_rd = 5'($urandom_range(0, 3));   mw_rd = 5'($urandom_range(0, 3));
      fd_use_a = 1'($urandom); fd_use_b = 1'($urandom); fd_we = 1'($urandom);
      fd_is_md = ($urandom_range(0, 3) == 0); dx_we = 1'($urandom);
      dx_is_load = ($urandom_range(0, 2) == 0); xm_we = 1'($urandom); mw_we = 1'($urandom);
      md_start = ($urandom_range(0, 5) == 0);
      md_rdy = !m_hv && ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      md_result = $urandom;
      @(negedge clock);
      chk($sformatf("rand_%0d", c), 64'(out_vec), 64'(model_out()));
      @(posedge clock);
      model_step();
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
